// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI serial-RAM controller.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    function automatic logic [7:0] cmd_for(input logic is_write);
        return is_write ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period timer: while enabled, alternates rise/fall strobes every HALF_DIV clk cycles.
module spi_clk_div #(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt_reg;
    logic       phase_reg;
    logic       tick;

    assign tick = en && (cnt_reg == 8'(HALF_DIV - 1));
    assign rise = tick && !phase_reg;
    assign fall = tick && phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Two-requester SPI serial-RAM controller (mode 0, one byte per frame).
// Define SPI_RAM_WRITE_EN to add the write path; otherwise every frame is a read.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int HALF_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic [7:0]        rdata,
    output logic              f_done,
    output logic              d_done,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int N     = 16 + ADDR_W;
    localparam int CNT_W = $clog2(N + 1);

    state_t            state_reg, state_next;
    req_id_t           last_gnt_reg, gnt_next;
    logic              grant;
    logic [N-1:0]      frame_next;
    logic [N-1:0]      tx_reg;
    logic [7:0]        rx_reg;
    logic [7:0]        rdata_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              sck_reg;
    logic              sck_rise, sck_fall;
    logic              shift_en;
    logic              rd_frame;

    // Data wins ties unless it also won last time while fetch was waiting.
    always_comb begin
        grant    = ena && (f_req || d_req) && (state_reg == IDLE);
        gnt_next = (d_req && !(f_req && last_gnt_reg == REQ_DATA)) ? REQ_DATA : REQ_FETCH;
    end

`ifdef SPI_RAM_WRITE_EN
    logic wr_next, wr_reg;
    assign wr_next    = (gnt_next == REQ_DATA) && d_we;
    assign frame_next = {cmd_for(wr_next),
                         (gnt_next == REQ_DATA) ? d_addr : f_addr,
                         wr_next ? d_wdata : 8'h00};
    assign rd_frame   = !wr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_reg <= 1'b0;
        else if (grant)
            wr_reg <= wr_next;
    end
`else
    logic unused_write_inputs;
    assign unused_write_inputs = ^{d_we, d_wdata};
    assign frame_next = {CMD_READ, (gnt_next == REQ_DATA) ? d_addr : f_addr, 8'h00};
    assign rd_frame   = 1'b1;
`endif

    assign shift_en = (state_reg == SHIFT);

    spi_clk_div #(.HALF_DIV(HALF_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = SETUP;
            SETUP:   state_next = SHIFT;
            SHIFT:   if (sck_fall && bit_cnt_reg == CNT_W'(N)) state_next = HOLD;
            HOLD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        spi_cs_n = (state_reg == IDLE) || (state_reg == DONE);
        f_done   = (state_reg == DONE) && (last_gnt_reg == REQ_FETCH);
        d_done   = (state_reg == DONE) && (last_gnt_reg == REQ_DATA);
    end

    // MISO is captured on SCK rise; MOSI only advances on SCK fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= REQ_FETCH;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rdata_reg    <= '0;
            bit_cnt_reg  <= '0;
            sck_reg      <= 1'b0;
        end else begin
            if (grant) begin
                last_gnt_reg <= gnt_next;
                tx_reg       <= frame_next;
                bit_cnt_reg  <= '0;
            end
            if (sck_rise) begin
                sck_reg <= 1'b1;
                rx_reg  <= {rx_reg[6:0], spi_miso};
                if (bit_cnt_reg != CNT_W'(N))
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (sck_fall) begin
                sck_reg <= 1'b0;
                tx_reg  <= {tx_reg[N-2:0], 1'b0};
            end
            // Loaded on entry to DONE so rdata is already valid during the done pulse.
            if (state_reg == HOLD && rd_frame)
                rdata_reg <= rx_reg;
        end
    end

    assign spi_sck  = sck_reg;
    assign spi_mosi = tx_reg[N-1];
    assign rdata    = rdata_reg;

endmodule
